// File: rtl/reg_file_bank.sv
// 32-entry register file: two combinational read ports, one write port, x0 hardwired to zero.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_bank #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] SP_RESET   = 32'h7FFF_EFFC,
  parameter logic [31:0] GP_RESET   = 32'h1000_8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [4:0]            Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [4:0]            Read_Register_1_i,
  input  logic [4:0]            Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

  localparam logic [DATA_WIDTH-1:0] SP_INIT = DATA_WIDTH'(SP_RESET);
  localparam logic [DATA_WIDTH-1:0] GP_INIT = DATA_WIDTH'(GP_RESET);

  logic [DATA_WIDTH-1:0] regs [32];
  logic                  write_active;
  logic                  bypass_1;
  logic                  bypass_2;

  assign write_active = Reg_Write_i && (Write_Register_i != 5'd0);

  // Async reset wins over any write, so an edge coinciding with reset is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      regs[2] <= SP_INIT;
      regs[3] <= GP_INIT;
    end else if (write_active) begin
      regs[Write_Register_i] <= Write_Data_i;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign bypass_1 = write_active && !reset && (Read_Register_1_i == Write_Register_i);
  assign bypass_2 = write_active && !reset && (Read_Register_2_i == Write_Register_i);
`else
  assign bypass_1 = 1'b0;
  assign bypass_2 = 1'b0;
`endif

  // x0 is forced to zero on the read side as well, independent of storage contents.
  always_comb begin
    Read_Data_1_o = regs[Read_Register_1_i];
    if (Read_Register_1_i == 5'd0) begin
      Read_Data_1_o = '0;
    end else if (bypass_1) begin
      Read_Data_1_o = Write_Data_i;
    end
  end

  always_comb begin
    Read_Data_2_o = regs[Read_Register_2_i];
    if (Read_Register_2_i == 5'd0) begin
      Read_Data_2_o = '0;
    end else if (bypass_2) begin
      Read_Data_2_o = Write_Data_i;
    end
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// Self-checking bench for reg_file_bank: directed scenarios plus random traffic
// compared against an array-based model of the register file.
`timescale 1ns/100ps
module tb_reg_file_bank;

  localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_VAL = 32'h1000_8000;

  logic        clock;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;

  logic [31:0] model [32];
  int          totalCount = 0;
  int          badCount = 0;

  reg_file_bank #(
    .DATA_WIDTH(32),
    .SP_RESET(SP_VAL),
    .GP_RESET(GP_VAL)
  ) dut (
    .clk(clock),
    .reset(reset),
    .Reg_Write_i(regWrite),
    .Write_Register_i(writeReg),
    .Write_Data_i(writeData),
    .Read_Register_1_i(readReg1),
    .Read_Register_2_i(readReg2),
    .Read_Data_1_o(readData1),
    .Read_Data_2_o(readData2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic void resetModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = SP_VAL;
    model[3] = GP_VAL;
  endfunction

  // Value a read port should show right now, given the pending write inputs.
  function automatic logic [31:0] expectedRead(input logic [4:0] rs);
`ifdef REG_FILE_BYPASS_EN
    if (regWrite && !reset && writeReg != 5'd0 && rs == writeReg) return writeData;
`endif
    if (rs == 5'd0) return 32'h0;
    return model[rs];
  endfunction

  // Called #1 after a rising edge; checks reads mid-cycle, then commits the write.
  task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    regWrite  = we;
    writeReg  = rd;
    writeData = wd;
    readReg1  = rs1;
    readReg2  = rs2;
    @(negedge clock);
    checkOutput($sformatf("rd1_x%0d", rs1), readData1, expectedRead(rs1));
    checkOutput($sformatf("rd2_x%0d", rs2), readData2, expectedRead(rs2));
    @(posedge clock);
    if (we && rd != 5'd0 && !reset) model[rd] = wd;
    #1;
  endtask

  initial begin
    logic        we;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] wd;

    reset = 1'b1;
    regWrite = 1'b0;
    writeReg = 5'd0;
    writeData = 32'h0;
    readReg1 = 5'd0;
    readReg2 = 5'd0;
    resetModel();

    // Reset values are visible before the first clock edge.
    #0.1;
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      #0.1;
      checkOutput($sformatf("rst_rd1_x%0d", i), readData1, model[i]);
      checkOutput($sformatf("rst_rd2_x%0d", 31 - i), readData2, model[31 - i]);
    end
    readReg1 = 5'd2;
    readReg2 = 5'd3;
    #0.1;
    checkOutput("rst_sp", readData1, 32'h7FFF_EFFC);
    checkOutput("rst_gp", readData2, 32'h1000_8000);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Basic write then read on both ports.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    checkOutput("x5_port1", readData1, 32'hDEAD_BEEF);
    checkOutput("x5_port2", readData2, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd6, 5'd4);
    checkOutput("x6_zero", readData1, 32'h0);

    // x0 write ignored, both same-cycle and afterwards.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("x0_after", readData1, 32'h0);

    // Disabled write leaves x7 untouched.
    applyStimulus(1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checkOutput("x7_nowrite", readData1, 32'h0);

    // Same-cycle read of the register being written.
    applyStimulus(1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    checkOutput("x9_next", readData1, 32'h2);

    // Reset between edges wipes writes; a write on an edge with reset high is dropped.
    applyStimulus(1'b1, 5'd10, 32'hA5A5_A5A5, 5'd0, 5'd0);
    readReg1 = 5'd10;
    readReg2 = 5'd2;
    regWrite = 1'b0;
    #1;
    checkOutput("x10_prereset", readData1, 32'hA5A5_A5A5);
    reset = 1'b1;
    resetModel();
    #1;
    checkOutput("x10_reset", readData1, 32'h0);
    checkOutput("sp_reset", readData2, SP_VAL);
    #1;
    applyStimulus(1'b1, 5'd11, 32'h5555_AAAA, 5'd11, 5'd10);
    applyStimulus(1'b1, 5'd2, 32'h0BAD_0BAD, 5'd11, 5'd2);
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd11, 5'd2);
    checkOutput("x11_dropped", readData1, 32'h0);
    checkOutput("sp_kept", readData2, SP_VAL);
    applyStimulus(1'b1, 5'd11, 32'hCAFE_F00D, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd11, 5'd11);
    checkOutput("x11_postreset", readData1, 32'hCAFE_F00D);

    // Random traffic, biased toward read/write address collisions, with rare reset pulses.
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      applyStimulus(we, rd, wd, rs1, rs2);
      if ($urandom_range(0, 49) == 0) begin
        regWrite = 1'b0;
        reset = 1'b1;
        resetModel();
        readReg1 = rd;
        #1;
        checkOutput("rand_reset", readData1, expectedRead(rd));
        reset = 1'b0;
        #1;
      end
    end

    // Final sweep of all registers against the model.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
